// File: rtl/pwm_counter.sv
// PWM timebase: prescaled 12-bit phase counter with sleep and oscillator wake-up delay.
// Feeds pwm_driver.counter_i and provides tick and period-start strobes.
module pwm_counter #(
  parameter logic [7:0] PRESCALE_DEFAULT = 8'd30,
  parameter logic [7:0] PRESCALE_MIN     = 8'd3,
  parameter int         WAKE_CYCLES      = 500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  prescale_i,
  input  logic        prescale_we_i,
  input  logic        sleep_i,
  output logic [11:0] counter_o,
  output logic        tick_o,
  output logic        cycle_start_o,
  output logic        running_o,
  output logic [7:0]  prescale_o
);

  localparam int                WAKE_W    = $clog2(WAKE_CYCLES) + 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);

  typedef enum logic [1:0] {
    ST_SLEEP = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        prescale_q, prescale_d;
  logic [11:0]       counter_q, counter_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              tick_q, tick_d;
  logic              cycle_start_q, cycle_start_d;
  logic              running_q, running_d;

  always_comb begin
    state_d       = state_q;
    prescale_d    = prescale_q;
    counter_d     = counter_q;
    div_cnt_d     = div_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    tick_d        = 1'b0;
    cycle_start_d = 1'b0;
    running_d     = running_q;

    case (state_q)
      ST_SLEEP: begin
        counter_d = 12'd0;
        div_cnt_d = 8'd0;
        running_d = 1'b0;
        // The divider is only reprogrammed while stopped, so a period never mixes rates.
        if (prescale_we_i) begin
          prescale_d = (prescale_i < PRESCALE_MIN) ? PRESCALE_MIN : prescale_i;
        end
        if (!sleep_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end

      ST_WAKE: begin
        if (sleep_i) begin
          state_d   = ST_SLEEP;
          running_d = 1'b0;
        end else if (wake_cnt_q == '0) begin
          state_d       = ST_RUN;
          counter_d     = 12'd0;
          div_cnt_d     = 8'd0;
          cycle_start_d = 1'b1;
          running_d     = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_ONE;
        end
      end

      ST_RUN: begin
        if (sleep_i) begin
          state_d   = ST_SLEEP;
          counter_d = 12'd0;
          div_cnt_d = 8'd0;
          running_d = 1'b0;
        end else if (div_cnt_q == prescale_q) begin
          div_cnt_d     = 8'd0;
          counter_d     = counter_q + 12'd1;
          tick_d        = 1'b1;
          cycle_start_d = (counter_q == 12'hFFF);
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = ST_SLEEP;
        counter_d = 12'd0;
        div_cnt_d = 8'd0;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_SLEEP;
      prescale_q    <= PRESCALE_DEFAULT;
      counter_q     <= 12'd0;
      div_cnt_q     <= 8'd0;
      wake_cnt_q    <= '0;
      tick_q        <= 1'b0;
      cycle_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prescale_q    <= prescale_d;
      counter_q     <= counter_d;
      div_cnt_q     <= div_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      tick_q        <= tick_d;
      cycle_start_q <= cycle_start_d;
      running_q     <= running_d;
    end
  end

  assign counter_o     = counter_q;
  assign tick_o        = tick_q;
  assign cycle_start_o = cycle_start_q;
  assign running_o     = running_q;
  assign prescale_o    = prescale_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter with a shortened wake-up delay of 4 clocks.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_pwm_counter;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  prescale_i;
  logic        prescale_we_i;
  logic        sleep_i;
  logic [11:0] counter_o;
  logic        tick_o;
  logic        cycle_start_o;
  logic        running_o;
  logic [7:0]  prescale_o;

  int vectors;
  int miscompares;
  int pulse_cnt;

  pwm_counter #(
    .PRESCALE_DEFAULT(8'd30),
    .PRESCALE_MIN    (8'd3),
    .WAKE_CYCLES     (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .prescale_i   (prescale_i),
    .prescale_we_i(prescale_we_i),
    .sleep_i      (sleep_i),
    .counter_o    (counter_o),
    .tick_o       (tick_o),
    .cycle_start_o(cycle_start_o),
    .running_o    (running_o),
    .prescale_o   (prescale_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advances n clocks and returns how many of them showed a high tick_o.
  task automatic count_ticks(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1);
      if (tick_o) cnt++;
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_i         = 1'b1;
    sleep_i       = 1'b1;
    prescale_we_i = 1'b0;
    prescale_i    = 8'd0;
    apply_stimulus(2);
    rst_i = 1'b0;

    // Reset state and idle in sleep
    check_output("rst_counter", counter_o, 0);
    check_output("rst_prescale", prescale_o, 30);
    check_output("rst_running", running_o, 0);
    check_output("rst_tick", tick_o, 0);
    check_output("rst_cstart", cycle_start_o, 0);
    count_ticks(100, pulse_cnt);
    check_output("idle_ticks", pulse_cnt, 0);

    // Prescale writes in sleep, including clamp
    prescale_i = 8'd1; prescale_we_i = 1'b1;
    apply_stimulus(1);
    check_output("clamp_1_to_3", prescale_o, 3);
    prescale_i = 8'd200;
    apply_stimulus(1);
    check_output("write_200", prescale_o, 200);
    prescale_i = 8'd3;
    apply_stimulus(1);
    prescale_we_i = 1'b0;
    check_output("write_3", prescale_o, 3);

    // Wake: sleep_i=0 sampled at edge E, RUN after E+4
    sleep_i = 1'b0;
    apply_stimulus(1);
    check_output("wake_e1_running", running_o, 0);
    apply_stimulus(3);
    check_output("wake_e3_running", running_o, 0);
    apply_stimulus(1);
    check_output("run_e4_running", running_o, 1);
    check_output("run_e4_cstart", cycle_start_o, 1);
    check_output("run_e4_counter", counter_o, 0);
    apply_stimulus(1);
    check_output("run_e5_cstart", cycle_start_o, 0);
    check_output("run_e5_tick", tick_o, 0);
    apply_stimulus(2);
    check_output("run_e7_counter", counter_o, 0);
    apply_stimulus(1);
    check_output("run_e8_counter", counter_o, 1);
    check_output("run_e8_tick", tick_o, 1);
    apply_stimulus(4);
    check_output("run_e12_counter", counter_o, 2);
    check_output("run_e12_tick", tick_o, 1);

    // Write in RUN is ignored and rate stays 4 clocks per step
    prescale_i = 8'd100; prescale_we_i = 1'b1;
    apply_stimulus(1);
    prescale_we_i = 1'b0;
    check_output("run_write_ignored", prescale_o, 3);
    apply_stimulus(3);
    check_output("run_e16_counter", counter_o, 3);
    check_output("run_e16_tick", tick_o, 1);

    // Wrap 4095 -> 0 at R+16384, R = E+4; now at E+16 = R+12
    apply_stimulus(16371);
    check_output("pre_wrap_counter", counter_o, 4095);
    check_output("pre_wrap_cstart", cycle_start_o, 0);
    apply_stimulus(1);
    check_output("wrap_counter", counter_o, 0);
    check_output("wrap_cstart", cycle_start_o, 1);
    check_output("wrap_tick", tick_o, 1);
    pulse_cnt = 0;
    for (int i = 0; i < 16383; i++) begin
      apply_stimulus(1);
      if (cycle_start_o) pulse_cnt++;
    end
    check_output("period_cstart_gap", pulse_cnt, 0);
    check_output("pre_wrap2_counter", counter_o, 4095);
    apply_stimulus(1);
    check_output("wrap2_cstart", cycle_start_o, 1);
    check_output("wrap2_counter", counter_o, 0);

    // Sleep mid-run at counter 0x7A3
    apply_stimulus(12'h7A3 * 4);
    check_output("mid_counter", counter_o, 12'h7A3);
    sleep_i = 1'b1;
    apply_stimulus(1);
    check_output("sleep_counter", counter_o, 0);
    check_output("sleep_running", running_o, 0);
    check_output("sleep_tick", tick_o, 0);
    count_ticks(20, pulse_cnt);
    check_output("sleep_no_ticks", pulse_cnt, 0);
    sleep_i = 1'b0;
    apply_stimulus(4);
    check_output("rewake_e3_running", running_o, 0);
    apply_stimulus(1);
    check_output("rewake_e4_running", running_o, 1);
    check_output("rewake_e4_cstart", cycle_start_o, 1);

    // Reset while running
    apply_stimulus(8);
    check_output("pre_rst_counter", counter_o, 2);
    rst_i = 1'b1;
    apply_stimulus(1);
    check_output("rst_run_counter", counter_o, 0);
    check_output("rst_run_running", running_o, 0);
    check_output("rst_run_prescale", prescale_o, 3 + 27);

    // Write together with wake in SLEEP, then reset during WAKE
    rst_i = 1'b0; prescale_i = 8'd7; prescale_we_i = 1'b1;
    apply_stimulus(1);
    prescale_we_i = 1'b0;
    check_output("wake_write_prescale", prescale_o, 7);
    check_output("wake_write_running", running_o, 0);
    apply_stimulus(1);
    rst_i = 1'b1;
    apply_stimulus(1);
    check_output("rst_wake_prescale", prescale_o, 30);
    check_output("rst_wake_running", running_o, 0);
    check_output("rst_wake_counter", counter_o, 0);
    rst_i = 1'b0; sleep_i = 1'b1;
    apply_stimulus(1);

    // Toggling sleep every cycle never reaches RUN
    pulse_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sleep_i = ~sleep_i;
      apply_stimulus(1);
      if (running_o) pulse_cnt++;
    end
    check_output("toggle_never_runs", pulse_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
